simple_proc_core: RTL
=====================

// Module: simple_proc_core
// PURPOSE
//  Parametrised multi-cycle processor core: NREG x WIDTH register file, A and G
//  staging registers, ALU and controller FSM behind a start/done handshake.
//  Next-generation replacement for the fixed 3-bit, 8-register, free-running FSM datapath.
//  Uses a muxed internal bus (no tri-states). Adds ADD/SUB/logic ops, error flag and an
//  optional iterative DIV/MOD unit.
// PARAMETERS
//  WIDTH  8  data width of registers, bus and ALU (>=2)
//  NREG   8  register count, power of 2 (>=2); AW = $clog2(NREG)
// PORTS
//  clk      in   1      single clock, rising edge
//  rst      in   1      asynchronous, active-high reset
//  start    in   1      request; accepted only when busy=0
//  func     in   4      opcode, latched on accept
//  rx       in   AW     destination / first operand register, latched on accept
//  ry       in   AW     second operand register, latched on accept
//  data_in  in   WIDTH  LOAD immediate, latched on accept
//  busy     out  1      high from accept edge until the write edge of the instruction
//  done     out  1      high for exactly the final cycle of an instruction
//  err      out  1      sticky: illegal opcode or divide-by-zero; cleared by next accept
//  rd_addr  in   AW     debug read address
//  rd_data  out  WIDTH  R[rd_addr], combinational
// BEHAVIOUR
//  Reset: all R[i]=0, A=0, G=0, state=IDLE, busy=0, done=0, err=0. Applies at any time,
//   including mid-instruction (a pending write is discarded).
//  Opcodes: 0001 LOAD Rx<=data_in | 0010 MOVE Rx<=Ry | 0011 ADD | 0100 SUB (Rx-Ry)
//   | 0101 AND | 0110 OR | 0111 XOR | 1000 DIV Rx<=Rx/Ry | 1001 MOD Rx<=Rx%Ry; others illegal.
//  ALU ops operate as Rx <= Rx op Ry. Arithmetic is unsigned and wraps modulo 2^WIDTH.
//  FSM: IDLE -> T1 -> {T2 -> T3 | T2 -> DIVW -> T3} -> IDLE.
//   IDLE: start=1 -> latch func/rx/ry/data_in, clear err, go T1.
//   T1  : LOAD/MOVE: write Rx at end of T1; done=1; -> IDLE (latency 1).
//         ALU/DIV/MOD: A<=R[rx]; -> T2. Illegal: err<=1, done=1, no write; -> IDLE.
//   T2  : ALU: G<=A op R[ry]; -> T3. DIV/MOD: load divider (A, R[ry]); -> DIVW.
//   DIVW: exactly WIDTH cycles, one quotient bit per cycle; G<=quot or rem; -> T3.
//   T3  : R[rx]<=G at end of cycle; done=1; -> IDLE.
//  Latency (accept edge to write edge): LOAD/MOVE 1, ALU 3, DIV/MOD WIDTH+3 cycles.
//  busy=1 in every non-IDLE state. A start asserted while busy is ignored (not queued).
//  Back-to-back: start may be held high; the next accept occurs on the first IDLE cycle.
//  rx==ry is legal, e.g. ADD R1,R1 doubles, SUB R1,R1 gives 0. MOVE Rx,Rx is a no-op write.
//  Divide by zero: quotient = all ones, remainder = dividend, err<=1; latency unchanged.
//  rd_data reflects a write starting the cycle after the write edge.
// CONFIGURATION
//  PROC_DIVMOD_EN defined  : DIV/MOD are implemented as above (instantiates proc_divider).
//  PROC_DIVMOD_EN undefined: 1000/1001 are treated as illegal opcodes (1-cycle, err=1,
//   no write). The DIVW state and the divider are not built.
// STRUCTURE
//  proc_pkg: opcode localparams (OP_LOAD..OP_MOD), FSM state encoding, ALU select codes.
//  Sub-module proc_divider: restoring unsigned divider, WIDTH-cycle, with ports
//   clk/rst/load/dividend/divisor -> quotient/remainder/valid/dz.
//  Top level contains the register file, A/G, bus mux, ALU case and controller FSM.
// TESTING (WIDTH=8, NREG=8)
//  Apply reset mid-DIV; then drop rst -> busy=0, done=0, err=0 and all rd_data=0 on the
//   next cycle. No write lands.
//  LOAD R2,0x5A -> done on cycle 1; rd_addr=2 reads 0x5A. Then MOVE R7,R2 -> R7=0x5A.
//  LOAD R0,0xF0; LOAD R1,0x20; ADD R0,R1 -> R0=0x10 (wrap), done 3 cycles after accept.
//   Then SUB R1,R1 -> 0.
//  Hold start high during an ADD with a different func -> second start ignored until IDLE.
//   Exactly one done per accepted instruction.
//  func=1111 -> err=1, done after 1 cycle, registers unchanged. Next valid accept clears err.
//  With PROC_DIVMOD_EN: R3=0x64, R4=0x07: DIV -> 0x0E, MOD -> 0x02, latency 11 cycles.
//   Divide by R5=0 -> R3=0xFF, err=1. Without the macro, the same DIV -> err=1 and R3 unchanged.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared definitions for simple_proc_core: opcodes, controller state codes and ALU select codes.
package proc_pkg;

  localparam logic [3:0] OP_LOAD = 4'b0001;
  localparam logic [3:0] OP_MOVE = 4'b0010;
  localparam logic [3:0] OP_ADD  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b0111;
  localparam logic [3:0] OP_DIV  = 4'b1000;
  localparam logic [3:0] OP_MOD  = 4'b1001;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_T1   = 3'd1;
  localparam logic [2:0] ST_T2   = 3'd2;
  localparam logic [2:0] ST_T3   = 3'd3;
  localparam logic [2:0] ST_DIVW = 3'd4;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_NONE
  } alu_sel_t;

  function automatic alu_sel_t alu_sel(input logic [3:0] func);
    case (func)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_XOR:  return ALU_XOR;
      default: return ALU_NONE;
    endcase
  endfunction

endpackage

// File: rtl/proc_divider.sv
// Restoring unsigned divider, one quotient bit per cycle over WIDTH cycles after load.
// quotient/remainder show the finished result during the cycle that valid is high.
module proc_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             valid,
  output logic             dz
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] q_r, r_r, d_r;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   shifted, diff;

  // A zero divisor never borrows, so the quotient fills with ones and the
  // remainder shifts in the whole dividend.
  always_comb begin
    shifted   = {r_r, q_r[WIDTH-1]};
    diff      = shifted - {1'b0, d_r};
    quotient  = {q_r[WIDTH-2:0], ~diff[WIDTH]};
    remainder = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  end

  assign valid = (cnt == CW'(1));
  assign dz    = (d_r == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r <= '0;
      r_r <= '0;
      d_r <= '0;
      cnt <= '0;
    end else if (load) begin
      q_r <= dividend;
      r_r <= '0;
      d_r <= divisor;
      cnt <= CW'(WIDTH);
    end else if (cnt != '0) begin
      q_r <= quotient;
      r_r <= remainder;
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/simple_proc_core.sv
// Multi-cycle processor core: register file, A/G staging, ALU and controller FSM.
// Define PROC_DIVMOD_EN to build the iterative DIV/MOD unit; otherwise DIV/MOD are illegal.
module simple_proc_core
  import proc_pkg::*;
#(
  parameter int  WIDTH = 8,
  parameter int  NREG  = 8,
  localparam int AW    = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       func,
  input  logic [AW-1:0]    rx,
  input  logic [AW-1:0]    ry,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic             err,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [2:0]       state;
  logic [3:0]       func_q;
  logic [AW-1:0]    rx_q, ry_q;
  logic [WIDTH-1:0] din_q, a_q, g_q;
  logic [WIDTH-1:0] regs [NREG];
  logic [WIDTH-1:0] bus, alu_out;
  logic             is_xfer, is_alu, is_div;

  assign is_xfer = (func_q == OP_LOAD) || (func_q == OP_MOVE);
  assign is_alu  = (func_q >= OP_ADD) && (func_q <= OP_XOR);

`ifdef PROC_DIVMOD_EN
  logic [WIDTH-1:0] quot, rem;
  logic             div_valid, div_dz;

  assign is_div = (func_q == OP_DIV) || (func_q == OP_MOD);

  proc_divider #(.WIDTH(WIDTH)) u_divider (
    .clk       (clk),
    .rst       (rst),
    .load      (state == ST_T2 && is_div),
    .dividend  (a_q),
    .divisor   (regs[ry_q]),
    .quotient  (quot),
    .remainder (rem),
    .valid     (div_valid),
    .dz        (div_dz)
  );
`else
  assign is_div = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    bus = g_q;
    if (state == ST_T1) bus = (func_q == OP_LOAD) ? din_q : regs[ry_q];
  end

  always_comb begin
    alu_out = a_q;
    case (alu_sel(func_q))
      ALU_ADD: alu_out = a_q + regs[ry_q];
      ALU_SUB: alu_out = a_q - regs[ry_q];
      ALU_AND: alu_out = a_q & regs[ry_q];
      ALU_OR:  alu_out = a_q | regs[ry_q];
      ALU_XOR: alu_out = a_q ^ regs[ry_q];
      default: alu_out = a_q;
    endcase
  end

  assign busy    = (state != ST_IDLE);
  assign done    = (state == ST_T3) || (state == ST_T1 && !(is_alu || is_div));
  assign rd_data = regs[rd_addr];

  // NOTE: the register file is reset on purpose; software relies on R[i]=0 after reset,
  // which also keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      func_q <= '0;
      rx_q   <= '0;
      ry_q   <= '0;
      din_q  <= '0;
      a_q    <= '0;
      g_q    <= '0;
      err    <= 1'b0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          func_q <= func;
          rx_q   <= rx;
          ry_q   <= ry;
          din_q  <= data_in;
          err    <= 1'b0;
          state  <= ST_T1;
        end
        ST_T1: begin
          if (is_xfer) begin
            regs[rx_q] <= bus;
            state      <= ST_IDLE;
          end else if (is_alu || is_div) begin
            a_q   <= regs[rx_q];
            state <= ST_T2;
          end else begin
            err   <= 1'b1;
            state <= ST_IDLE;
          end
        end
        ST_T2: begin
          g_q   <= alu_out;
          state <= is_div ? ST_DIVW : ST_T3;
        end
`ifdef PROC_DIVMOD_EN
        ST_DIVW: if (div_valid) begin
          g_q <= (func_q == OP_MOD) ? rem : quot;
          if (div_dz) err <= 1'b1;
          state <= ST_T3;
        end
`endif
        ST_T3: begin
          regs[rx_q] <= bus;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
